// File: rtl/fsm_esteira_multi.sv
// Multi-destination conveyor belt controller: drives the belt toward a selected station,
// debounces that station's sensor, pauses on the cork alarm and flags a move timeout.
module fsm_esteira_multi #(
  parameter int N_DEST         = 3,
  parameter int DEST_W         = 2,
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_mover,
  input  logic [DEST_W-1:0] dest_sel,
  input  logic [N_DEST-1:0] sensores,
  input  logic              alarme_rolha,
  output logic              motor_ativo,
  output logic              tarefa_concluida,
  output logic              erro_timeout,
  output logic              pausado,
  output logic [2:0]        estado,
  output logic [DEST_W-1:0] dest_ativo
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVENDO = 3'd1,
    PARADO  = 3'd2,
    PAUSA   = 3'd3,
    ERRO    = 3'd4
  } state_t;

  localparam int                N_SEL     = 2 ** DEST_W;
  localparam logic [DEST_W:0]   N_DEST_W  = (DEST_W + 1)'(N_DEST);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [DEST_W-1:0] dest_reg, dest_next;
  logic [CNT_W-1:0]  deb_cnt_reg, deb_cnt_next;
  logic [CNT_W-1:0]  tmo_cnt_reg, tmo_cnt_next;

  // Zero-padded so any latched index selects a defined bit.
  logic [N_SEL-1:0]  sens_pad;
  logic              sel_sensor;
  logic              dest_ok;

  always_comb begin
    sens_pad = '0;
    sens_pad[N_DEST-1:0] = sensores;
  end

  assign sel_sensor = sens_pad[dest_reg];
  assign dest_ok    = ({1'b0, dest_sel} < N_DEST_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      dest_reg    <= '0;
      deb_cnt_reg <= '0;
      tmo_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      dest_reg    <= dest_next;
      deb_cnt_reg <= deb_cnt_next;
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    dest_next    = dest_reg;
    deb_cnt_next = deb_cnt_reg;
    tmo_cnt_next = tmo_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_mover && !alarme_rolha && dest_ok) begin
          state_next   = MOVENDO;
          dest_next    = dest_sel;
          deb_cnt_next = '0;
          tmo_cnt_next = '0;
        end
      end
      MOVENDO: begin
        tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
        deb_cnt_next = sel_sensor ? deb_cnt_reg + CNT_W'(1) : '0;
        if (!cmd_mover)                             state_next = IDLE;
        else if (alarme_rolha)                      state_next = PAUSA;
        else if (sel_sensor && deb_cnt_reg == DEB_LAST) state_next = PARADO;
        else if (tmo_cnt_reg == TMO_LAST)           state_next = ERRO;
      end
      PAUSA: begin
        // Timeout count is frozen here; debounce restarts after the pause.
        deb_cnt_next = '0;
        if (!cmd_mover)         state_next = IDLE;
        else if (!alarme_rolha) state_next = MOVENDO;
      end
      PARADO, ERRO: begin
        if (!cmd_mover) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Motor drops combinationally on the alarm, one cycle before PAUSA is entered.
  assign motor_ativo      = (state_reg == MOVENDO) && !alarme_rolha;
  assign tarefa_concluida = (state_reg == PARADO);
  assign erro_timeout     = (state_reg == ERRO);
  assign pausado          = (state_reg == PAUSA);
  assign estado           = state_reg;
  assign dest_ativo       = dest_reg;

endmodule
